// File: rtl/bitmap_buf.sv
// bitmap_buf -- double-buffered bitmap store between a byte-stream loader
// and a display read port.
//
// One bank is displayed (active_bank) while the loader fills the other bank.
// When the inactive bank is full, the loader waits for a vsync falling edge.
// On that edge the banks swap and the loader starts again.
//
// Parameters:
//   AW          read/write address width (2^AW bytes per bank)
//   DW          pixel-byte width
//   TIMEOUT_CYC idle cycles before a partial load is discarded
//               (used only when BITMAP_BUF_TIMEOUT_EN is defined)
//
// Optional feature macro:
//   BITMAP_BUF_TIMEOUT_EN  enables the idle counter that rewinds wr_ptr to 0
//                          after TIMEOUT_CYC idle cycles mid-load.
//
// Ports:
//   clk          system/pixel clock; all logic uses the rising edge
//   rst_n        asynchronous active-low reset
//   s_data       incoming bitmap byte (bit k = pixel column k)
//   s_valid      s_data valid
//   s_ready      block accepts s_data this cycle
//   vsync        active-low vertical sync, synchronous to clk
//   rd_addr      display read address
//   rd_q         registered byte at rd_addr in the active bank (1-cycle latency)
//   active_bank  bank currently being displayed
//   swap_pulse   one-cycle pulse on each bank swap
module bitmap_buf #(
    parameter int unsigned AW          = 6,
    parameter int unsigned DW          = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          vsync,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_q,
    output logic          active_bank,
    output logic          swap_pulse
);

    typedef enum logic {
        LOAD      = 1'b0,
        WAIT_SWAP = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] wr_ptr;
    logic          vs_d;
    logic          vs_fall;
    logic          wr_en;
    logic          do_swap;
    logic          idle_hit;

    // Both banks live in one array; the MSB of the index selects the bank.
    logic [DW-1:0] mem [2**(AW+1)];

    assign vs_fall = vs_d & ~vsync;

    // Loader FSM: next state and outputs
    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        wr_en    = 1'b0;
        do_swap  = 1'b0;
        unique case (state)
            LOAD: begin
                // A vsync edge in LOAD is ignored. This includes the cycle
                // in which the final byte is accepted.
                s_ready = 1'b1;
                wr_en   = s_valid;
                if (s_valid && (wr_ptr == '1)) begin
                    state_nx = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (vs_fall) begin
                    do_swap  = 1'b1;
                    state_nx = LOAD;
                end
            end
        endcase
    end

`ifdef BITMAP_BUF_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] idle_cnt;
    logic          idle_cyc;

    // Counts only while a load is partially complete and no byte arrives.
    assign idle_cyc = (state == LOAD) && !s_valid && (wr_ptr != '0);
    assign idle_hit = idle_cyc && (idle_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!idle_cyc || idle_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign idle_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            wr_ptr      <= '0;
            vs_d        <= 1'b1;
            active_bank <= 1'b0;
            swap_pulse  <= 1'b0;
        end else begin
            state       <= state_nx;
            vs_d        <= vsync;
            active_bank <= active_bank ^ do_swap;
            swap_pulse  <= do_swap;
            if (wr_en) begin
                // wr_ptr wraps from 2^AW-1 to 0 on the final byte.
                wr_ptr <= wr_ptr + 1'b1;
            end else if (idle_hit) begin
                wr_ptr <= '0;
            end
        end
    end

    // RAM is not reset, so its contents persist across a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{~active_bank, wr_ptr}] <= s_data;
        end
    end

    // The read uses the pre-edge active_bank. On the swap edge, rd_q
    // therefore still returns data from the old bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[{active_bank, rd_addr}];
        end
    end

endmodule

// File: tb/tb_bitmap_buf.sv
// tb_bitmap_buf -- directed, self-checking bench for bitmap_buf (AW=6, DW=8,
// TIMEOUT_CYC=16). Inputs are driven and outputs sampled 1 time unit after
// each rising edge.
module tb_bitmap_buf;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       vsync;
    logic [5:0] rd_addr;
    logic [7:0] rd_q;
    logic       active_bank;
    logic       swap_pulse;

    int errors    = 0;
    int checks    = 0;
    int pulse_cnt = 0;

    bitmap_buf #(
        .AW         (6),
        .DW         (8),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .vsync      (vsync),
        .rd_addr    (rd_addr),
        .rd_q       (rd_q),
        .active_bank(active_bank),
        .swap_pulse (swap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (swap_pulse === 1'b1) pulse_cnt++;
    end

    typedef struct {
        logic [5:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One byte per cycle with s_valid high, and no wait on s_ready.
    task automatic stream(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            s_data  = base + 8'(i);
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] q);
        rd_addr = a;
        tick();
        q = rd_q;
    endtask

    task automatic swap_edge(input string tag, input logic exp_bank);
        vsync = 1'b0;
        tick();
        check({tag, "_pulse_hi"}, swap_pulse, 1);
        check({tag, "_bank"}, active_bank, exp_bank);
        check({tag, "_ready"}, s_ready, 1);
        vsync = 1'b1;
        tick();
        check({tag, "_pulse_lo"}, swap_pulse, 0);
    endtask

    logic [7:0] q;
    int         p0;
    logic [7:0] exp0, exp5, exp63;

    initial begin
        // Bank 0 holds 0x80+addr when this table is applied.
        vecs[0] = '{6'h00, 8'h80};
        vecs[1] = '{6'h01, 8'h81};
        vecs[2] = '{6'h1F, 8'h9F};
        vecs[3] = '{6'h20, 8'hA0};
        vecs[4] = '{6'h3E, 8'hBE};
        vecs[5] = '{6'h3F, 8'hBF};

        rst_n = 1'b0; vsync = 1'b1; s_valid = 1'b0; s_data = '0; rd_addr = '0;
        tick(); tick();
        check("rst_bank", active_bank, 0);
        check("rst_pulse", swap_pulse, 0);
        check("rst_rdq", rd_q, 0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", s_ready, 1);

        // Fill bank 1 with 0x00..0x3F.
        stream(8'h00, 63);
        check("ready_before_last", s_ready, 1);
        stream(8'h3F, 1);
        check("ready_after_last", s_ready, 0);
        tick(); tick();
        check("wait_ready", s_ready, 0);
        check("wait_bank", active_bank, 0);
        check("no_pulse_load", pulse_cnt, 0);

        swap_edge("swap1", 1'b1);
        rd(6'h05, q);
        check("swap1_rd5", q, 8'h05);
        check("swap1_one_pulse", pulse_cnt, 1);

        // Fill bank 0 with 0x80+i while bank 1 stays displayed.
        stream(8'h80, 64);
        rd(6'h28, q);
        check("persist_b1", q, 8'h28);
        // A read in the swap cycle returns the old bank. The next read returns the new bank.
        rd_addr = 6'h03;
        vsync   = 1'b0;
        tick();
        check("swapcyc_old", rd_q, 8'h03);
        check("swap2_bank", active_bank, 0);
        check("swap2_pulse", swap_pulse, 1);
        vsync = 1'b1;
        tick();
        check("swapcyc_new", rd_q, 8'h83);

        for (int i = 0; i < 6; i++) begin
            rd(vecs[i].addr, q);
            check($sformatf("tbl_rd%0d", i), q, vecs[i].exp);
        end

        // Final byte accepted in the same cycle as a vsync fall: no swap on that edge.
        p0 = pulse_cnt;
        stream(8'h10, 63);
        s_data = 8'h4F; s_valid = 1'b1; vsync = 1'b0;
        tick();
        s_valid = 1'b0;
        check("coinc_ready", s_ready, 0);
        check("coinc_bank", active_bank, 0);
        tick();
        vsync = 1'b1;
        tick();
        check("coinc_no_pulse", pulse_cnt, p0);
        check("coinc_bank2", active_bank, 0);
        swap_edge("swap3", 1'b1);
        rd(6'h00, q);
        check("swap3_rd0", q, 8'h10);
        rd(6'h3F, q);
        check("swap3_rd63", q, 8'h4F);

        // Reset in the middle of a load.
        stream(8'h55, 10);
        rst_n = 1'b0;
        tick();
        check("midrst_bank", active_bank, 0);
        rst_n = 1'b1;
        tick();
        stream(8'hA0, 64);
        check("midrst_ready", s_ready, 0);
        swap_edge("swap4", 1'b1);
        rd(6'h00, q);
        check("midrst_rd0", q, 8'hA0);
        rd(6'h09, q);
        check("midrst_rd9", q, 8'hA9);
        rd(6'h3F, q);
        check("midrst_rd63", q, 8'hDF);

        // 5 bytes, 16 idle cycles, then a 64-byte burst into bank 0.
        stream(8'h20, 5);
        repeat (16) tick();
        stream(8'h40, 64);
        check("to_ready", s_ready, 0);
`ifdef BITMAP_BUF_TIMEOUT_EN
        exp0 = 8'h40; exp5 = 8'h45; exp63 = 8'h7F;
`else
        // No rewind: the burst fills addresses 5..63 with 0x40..0x7A, then
        // waits. Address 0 keeps the first byte of the short load.
        exp0 = 8'h20; exp5 = 8'h40; exp63 = 8'h7A;
`endif
        swap_edge("swap5", 1'b0);
        rd(6'h00, q);
        check("to_rd0", q, exp0);
        rd(6'h05, q);
        check("to_rd5", q, exp5);
        rd(6'h3F, q);
        check("to_rd63", q, exp63);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
